// File: rtl/ram_buffer.sv
// ram_buffer: feature-map RAM with registered read, a weight streaming path
// and a 5-row line buffer whose taps present one column of 5 consecutive rows.
module ram_buffer #(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_WIDTH        = 10,
    parameter int MAX_WIDTH         = 28,
    parameter int FEATURE_MAP1_SIZE = 28,
    parameter     INIT_FILE         = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WorI,
    input  logic [2:0]            mode,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  en,
    input  logic                  ram_write_en,
    input  logic [ADDR_WIDTH-1:0] ram_write_addr,
    input  logic [DATA_WIDTH-1:0] ram_write_data,
    output logic [DATA_WIDTH-1:0] out0,
    output logic [DATA_WIDTH-1:0] out1,
    output logic [DATA_WIDTH-1:0] out2,
    output logic [DATA_WIDTH-1:0] out3,
    output logic [DATA_WIDTH-1:0] out4,
    output logic [ADDR_WIDTH-1:0] read_addr_out,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic [DATA_WIDTH-1:0] ram_output,
    output logic [4:0]            out_valid
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int STAGES = 4 * MAX_WIDTH + 1;
    localparam int IDX_W  = $clog2(STAGES + 1);
    localparam logic [IDX_W-1:0] CNT_SAT = IDX_W'(STAGES);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [DATA_WIDTH-1:0] ram_output_q;
    logic [ADDR_WIDTH-1:0] read_addr_out_q;
    logic                  en_dly_q, en_dly_d;
    logic                  wori_dly_q, wori_dly_d;
    logic [2:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] weight_out_q, weight_out_d;
    logic [DATA_WIDTH-1:0] lb_q [0:STAGES-1];
    logic [DATA_WIDTH-1:0] lb_d [0:STAGES-1];
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [4:0]            valid_q, valid_d;

    logic                  shift_en;
    logic                  weight_load;
    logic                  mode_changed;
    logic [IDX_W-1:0]      row_len;
    logic [IDX_W-1:0]      tap_idx [0:4];
    logic [IDX_W-1:0]      thr     [0:4];
    logic [DATA_WIDTH-1:0] tap     [0:4];

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_write_en) begin
            mem[ram_write_addr] <= ram_write_data;
        end
    end

    // Registered read port (read-first on address collision), holds when en=0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_output_q    <= '0;
            read_addr_out_q <= '0;
        end else if (en) begin
            ram_output_q    <= mem[read_addr];
            read_addr_out_q <= read_addr;
        end
    end

    // Row length decoded from mode
    always_comb begin
        row_len = IDX_W'(FEATURE_MAP1_SIZE);
        case (mode)
            3'b001:  row_len = IDX_W'(24);
            3'b010:  row_len = IDX_W'(12);
            3'b011:  row_len = IDX_W'(8);
            3'b100:  row_len = IDX_W'(4);
            default: row_len = IDX_W'(FEATURE_MAP1_SIZE);
        endcase
    end

    // Tap k sits k rows back; it is valid once k rows plus one pixel have shifted in
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_tap
            assign tap_idx[gi] = IDX_W'(gi) * row_len;
            assign thr[gi]     = tap_idx[gi] + IDX_W'(1);
            assign tap[gi]     = lb_q[tap_idx[gi]];
        end
    endgenerate

    assign shift_en     = en_dly_q && !wori_dly_q;
    assign weight_load  = en_dly_q && wori_dly_q;
    assign mode_changed = (mode != mode_q);

    // Next-state: pipeline flags, weight latch, line-buffer shift, pixel counter
    always_comb begin
        en_dly_d     = en;
        wori_dly_d   = WorI;
        mode_d       = mode;
        weight_out_d = weight_load ? ram_output_q : weight_out_q;
        lb_d         = lb_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        if (shift_en) begin
            lb_d[0] = ram_output_q;
            for (int i = 1; i < STAGES; i++) begin
                lb_d[i] = lb_q[i-1];
            end
        end
        if (mode_changed) begin
            // New row length invalidates everything in flight
            cnt_d   = '0;
            valid_d = '0;
        end else if (shift_en) begin
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + IDX_W'(1);
            end
            for (int k = 0; k < 5; k++) begin
                if (cnt_d >= thr[k]) begin
                    valid_d[k] = 1'b1;
                end
            end
        end
    end

    // State register for flags, weight latch, line buffer and counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_dly_q     <= 1'b0;
            wori_dly_q   <= 1'b0;
            mode_q       <= 3'b000;
            weight_out_q <= '0;
            cnt_q        <= '0;
            valid_q      <= '0;
            for (int i = 0; i < STAGES; i++) begin
                lb_q[i] <= '0;
            end
        end else begin
            en_dly_q     <= en_dly_d;
            wori_dly_q   <= wori_dly_d;
            mode_q       <= mode_d;
            weight_out_q <= weight_out_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            lb_q         <= lb_d;
        end
    end

    assign out0          = tap[0];
    assign out1          = tap[1];
    assign out2          = tap[2];
    assign out3          = tap[3];
    assign out4          = tap[4];
    assign ram_output    = ram_output_q;
    assign read_addr_out = read_addr_out_q;
    assign weight_out    = weight_out_q;
    assign out_valid     = valid_q;

endmodule

// File: tb/tb_ram_buffer.sv
// Directed bench for ram_buffer: reset, weight streaming, line-buffer taps per
// mode, read-first collision and asynchronous reset mid-stream.
module tb_ram_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       WorI;
    logic [2:0] mode;
    logic [9:0] read_addr;
    logic       en;
    logic       ram_write_en;
    logic [9:0] ram_write_addr;
    logic [7:0] ram_write_data;
    logic [7:0] out0, out1, out2, out3, out4;
    logic [9:0] read_addr_out;
    logic [7:0] weight_out;
    logic [7:0] ram_output;
    logic [4:0] out_valid;
    logic [7:0] taps [0:4];

    int vectors = 0;
    int errors  = 0;

    ram_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .WorI           (WorI),
        .mode           (mode),
        .read_addr      (read_addr),
        .en             (en),
        .ram_write_en   (ram_write_en),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .out0           (out0),
        .out1           (out1),
        .out2           (out2),
        .out3           (out3),
        .out4           (out4),
        .read_addr_out  (read_addr_out),
        .weight_out     (weight_out),
        .ram_output     (ram_output),
        .out_valid      (out_valid)
    );

    always #5 clk = ~clk;

    assign taps[0] = out0;
    assign taps[1] = out1;
    assign taps[2] = out2;
    assign taps[3] = out3;
    assign taps[4] = out4;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int addr, input int data);
        logic [9:0] a;
        logic [7:0] d;
        a = addr[9:0];
        d = data[7:0];
        ram_write_en   = 1'b1;
        ram_write_addr = a;
        ram_write_data = d;
        tick();
        ram_write_en   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; WorI = 1'b0; mode = 3'b000; read_addr = '0; en = 1'b0;
        ram_write_en = 1'b0; ram_write_addr = '0; ram_write_data = '0;
        tick(); tick();
        vectors++;
        if ({out0, out1, out2, out3, out4} !== 40'h0) begin
            $display("FAIL reset_taps got=%h want=0", {out0, out1, out2, out3, out4}); errors++;
        end
        vectors++;
        if (out_valid !== 5'b00000) begin
            $display("FAIL reset_valid got=%b want=00000", out_valid); errors++;
        end
        vectors++;
        if ({ram_output, weight_out, read_addr_out} !== 26'h0) begin
            $display("FAIL reset_ram_regs got=%h/%h/%h want=0", ram_output, weight_out, read_addr_out); errors++;
        end
        rst = 1'b0;
        tick();
        write_word(3, 'h5A);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        WorI = 1'b1; en = 1'b1; read_addr = 10'd3;
        tick();
        en = 1'b0;
        vectors++;
        if (ram_output !== 8'h5A) begin
            $display("FAIL ram_survives_reset got=%h want=5a", ram_output); errors++;
        end
        vectors++;
        if (read_addr_out !== 10'd3) begin
            $display("FAIL read_addr_out got=%0d want=3", read_addr_out); errors++;
        end
        $display("test_reset done");
    endtask

    task automatic test_weight;
        logic [7:0] exp_b;
        for (int i = 0; i < 25; i++) write_word(800 + i, i + 1);
        WorI = 1'b1; en = 1'b1;
        for (int i = 0; i < 25; i++) begin
            read_addr = 10'(800 + i);
            tick();
            exp_b = 8'(i + 1);
            vectors++;
            if (ram_output !== exp_b) begin
                $display("FAIL weight_ram_output i=%0d got=%h want=%h", i, ram_output, exp_b); errors++;
            end
            vectors++;
            if (read_addr_out !== 10'(800 + i)) begin
                $display("FAIL weight_addr_out i=%0d got=%0d want=%0d", i, read_addr_out, 800 + i); errors++;
            end
            if (i > 0) begin
                vectors++;
                if (weight_out !== 8'(i)) begin
                    $display("FAIL weight_out i=%0d got=%h want=%h", i, weight_out, 8'(i)); errors++;
                end
            end
            vectors++;
            if (out_valid !== 5'b00000) begin
                $display("FAIL weight_valid i=%0d got=%b want=00000", i, out_valid); errors++;
            end
        end
        en = 1'b0;
        tick();
        vectors++;
        if (weight_out !== 8'd25) begin
            $display("FAIL weight_out_last got=%h want=19", weight_out); errors++;
        end
        tick();
        vectors++;
        if (weight_out !== 8'd25 || ram_output !== 8'd25) begin
            $display("FAIL weight_hold got=%h/%h want=19/19", weight_out, ram_output); errors++;
        end
        $display("test_weight done");
    endtask

    task automatic fill_ram;
        for (int a = 0; a < 1024; a++) write_word(a, a);
    endtask

    task automatic test_mode(input logic [2:0] m, input int w, input int nreads);
        logic [4:0] exp_v;
        logic [7:0] exp_b;
        int         e;
        int         tap_err;
        en = 1'b0; WorI = 1'b0; mode = m;
        tick(); tick();
        vectors++;
        if (out_valid !== 5'b00000) begin
            $display("FAIL mode_change_clear mode=%b got=%b want=00000", m, out_valid); errors++;
        end
        tap_err = 0;
        for (int t = 0; t < nreads; t++) begin
            read_addr = 10'(t);
            en = 1'b1;
            tick();
            // t shifts have completed after this edge
            exp_v = '0;
            for (int k = 0; k < 5; k++) if (t >= k * w + 1) exp_v[k] = 1'b1;
            vectors++;
            if (out_valid !== exp_v) begin
                $display("FAIL valid mode=%b shift=%0d got=%b want=%b", m, t, out_valid, exp_v); errors++;
            end
            for (int k = 0; k < 5; k++) begin
                if (t >= k * w + 1) begin
                    e = t - 1 - k * w;
                    exp_b = e[7:0];
                    vectors++;
                    if (taps[k] !== exp_b) begin
                        if (tap_err < 10)
                            $display("FAIL tap%0d mode=%b shift=%0d got=%h want=%h", k, m, t, taps[k], exp_b);
                        tap_err++;
                        errors++;
                    end
                end
            end
        end
        en = 1'b0;
        $display("test_mode mode=%b width=%0d reads=%0d done", m, w, nreads);
    endtask

    task automatic test_back_to_back;
        WorI = 1'b1; en = 1'b1; read_addr = 10'd5;
        ram_write_en = 1'b1; ram_write_addr = 10'd5; ram_write_data = 8'hAA;
        tick();
        ram_write_en = 1'b0;
        vectors++;
        if (ram_output !== 8'h05) begin
            $display("FAIL read_first got=%h want=05", ram_output); errors++;
        end
        tick();
        vectors++;
        if (ram_output !== 8'hAA) begin
            $display("FAIL read_after_write got=%h want=aa", ram_output); errors++;
        end
        en = 1'b0;
        write_word(5, 5);
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_midstream;
        test_mode(3'b000, 28, 41);
        vectors++;
        if (out_valid !== 5'b00011) begin
            $display("FAIL pre_reset_valid got=%b want=00011", out_valid); errors++;
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({out0, out1, out2, out3, out4} !== 40'h0) begin
            $display("FAIL async_reset_taps got=%h want=0", {out0, out1, out2, out3, out4}); errors++;
        end
        vectors++;
        if (out_valid !== 5'b00000 || ram_output !== 8'h00) begin
            $display("FAIL async_reset_valid got=%b/%h want=00000/00", out_valid, ram_output); errors++;
        end
        #2;
        rst = 1'b0;
        test_mode(3'b000, 28, 150);
        $display("test_reset_midstream done");
    endtask

    initial begin
        test_reset();
        test_weight();
        fill_ram();
        test_mode(3'b000, 28, 1024);
        test_mode(3'b001, 24, 200);
        test_mode(3'b010, 12, 200);
        test_mode(3'b011, 8, 200);
        test_mode(3'b100, 4, 200);
        test_mode(3'b110, 28, 150);
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
